adder_tree_driver: RTL and testbench



---
 rtl/adder_tree_pkg.sv | 18 +
 rtl/adder_tree_driver_if.sv | 29 ++
 rtl/adder_tree_driver.sv | 108 ++++++++++
 tb/tb_adder_tree_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants, state encoding and width helpers
// for the adder tree driver and its interface.
package adder_tree_pkg;

   localparam int ADDER_WIDTH_DEF = 21;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      WAIT   = 2'd1,
      RESULT = 2'd2
   } state_t;

   // Wide enough to hold the exact sum of a full batch.
   function automatic int acc_width(int aw, int lanes);
      return aw + $clog2(lanes);
   endfunction

endpackage

// File: rtl/adder_tree_driver_if.sv
// Operand input stream and result output stream
// of the adder tree driver.
interface adder_tree_driver_if
   import adder_tree_pkg::*;
#(
   parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
   parameter int SUM_WIDTH   = ADDER_WIDTH + 1
);

   logic                   in_valid;
   logic                   in_ready;
   logic [ADDER_WIDTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [SUM_WIDTH-1:0]   out_sum;

   // Environment side: supplies operands, consumes results.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum
   );

   // Driver block side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum
   );

endinterface

// File: rtl/adder_tree_driver.sv
// Collects a batch of operands for the adder tree, waits out
// its latency, returns its sum and flags any disagreement.
module adder_tree_driver
   import adder_tree_pkg::*;
#(
   parameter int ADDER_WIDTH  = ADDER_WIDTH_DEF,
   parameter int LANES        = 4,
   parameter int SUM_WIDTH    = ADDER_WIDTH + 1,
   parameter int TREE_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   adder_tree_driver_if.slave           bus,
   output logic [LANES*ADDER_WIDTH-1:0] lane_data,
   input  logic [SUM_WIDTH-1:0]         tree_sum,
   output logic                         err_mismatch
);

   localparam int ACC_W = acc_width(ADDER_WIDTH, LANES);
   localparam int IDX_W = $clog2(LANES);
   localparam int WCW   = $clog2(TREE_LATENCY + 2);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);
   localparam logic [WCW-1:0]   WLAT = WCW'(TREE_LATENCY);
   // Only the low SUM_WIDTH bits take part in the check.
   localparam logic [ACC_W-1:0] SUM_MASK =
      {ACC_W{1'b1}} >> (ACC_W - SUM_WIDTH);

   state_t                 state, state_n;
   logic [IDX_W-1:0]       idx;
   logic [ACC_W-1:0]       acc;
   logic [WCW-1:0]         wait_cnt;
   logic [ADDER_WIDTH-1:0] lane [LANES];

   logic accept;
   logic last_acc;
   logic capture;
   logic handshake;
   logic mismatch;

   assign accept    = bus.in_valid && bus.in_ready;
   assign last_acc  = accept && (idx == LAST);
   assign capture   = (state == WAIT) && (wait_cnt == '0);
   assign handshake = bus.out_valid && bus.out_ready;
   assign mismatch  =
      |((acc ^ ACC_W'(tree_sum)) & SUM_MASK);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_data[g*ADDER_WIDTH +: ADDER_WIDTH] = lane[g];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_n;
   end

   // Next state; in_ready decoded from state alone.
   always_comb begin
      state_n      = state;
      bus.in_ready = 1'b0;
      unique case (state)
         FILL: begin
            bus.in_ready = 1'b1;
            if (last_acc) state_n = WAIT;
         end
         WAIT: begin
            if (wait_cnt == '0) state_n = RESULT;
         end
         RESULT: begin
            if (handshake) state_n = FILL;
         end
         default: state_n = FILL;
      endcase
   end

   // Lane buffer, accumulator, latency counter and result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx           <= '0;
         acc           <= '0;
         wait_cnt      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         err_mismatch  <= 1'b0;
         for (int i = 0; i < LANES; i++) lane[i] <= '0;
      end else begin
         if (accept) begin
            lane[idx] <= bus.in_data;
            idx       <= last_acc ? '0 : idx + 1'b1;
            acc       <= acc + ACC_W'(bus.in_data);
         end
         if (last_acc) wait_cnt <= WLAT;
         else if (state == WAIT && !capture)
            wait_cnt <= wait_cnt - 1'b1;
         if (capture) begin
            bus.out_sum   <= tree_sum;
            bus.out_valid <= 1'b1;
            if (mismatch) err_mismatch <= 1'b1;
         end
         if (state == RESULT && handshake) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_driver.sv
// Directed bench for adder_tree_driver with a small
// two-level pipelined tree model beside it.
module tb_adder_tree_driver;

   localparam int AW = 21;
   localparam int SW = 22;
   localparam int LN = 4;

   logic clk;
   logic rst_n;
   logic [LN*AW-1:0] lane_data;
   logic [SW-1:0]    tree_sum;
   logic             err_mismatch;
   logic             force_en;

   int total  = 0;
   int passed = 0;

   adder_tree_driver_if #(.ADDER_WIDTH(AW), .SUM_WIDTH(SW)) bus ();

   adder_tree_driver #(
      .ADDER_WIDTH(AW), .LANES(LN),
      .SUM_WIDTH(SW), .TREE_LATENCY(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .lane_data(lane_data),
      .tree_sum(tree_sum),
      .err_mismatch(err_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tree model: pair sums then final sum, two register stages.
   logic [SW-1:0] s01 = '0;
   logic [SW-1:0] s23 = '0;
   logic [SW-1:0] tsum = '0;
   always_ff @(posedge clk) begin
      s01  <= SW'(lane_data[0*AW +: AW]) + SW'(lane_data[1*AW +: AW]);
      s23  <= SW'(lane_data[2*AW +: AW]) + SW'(lane_data[3*AW +: AW]);
      tsum <= s01 + s23;
   end
   assign tree_sum = force_en ? SW'(11) : tsum;

   task automatic check(string tag, logic [127:0] obs,
                        logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp);
   endtask

   task automatic send4(logic [AW-1:0] a, logic [AW-1:0] b,
                        logic [AW-1:0] c, logic [AW-1:0] d);
      logic [AW-1:0] v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = v[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   // Called on the negedge right after the final accepting edge.
   task automatic get_result(string tag, logic [SW-1:0] exp_sum,
                             logic exp_err);
      int n;
      n = 0;
      while (!bus.out_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 128'(n), 128'(3));
      check({tag, " sum"}, 128'(bus.out_sum), 128'(exp_sum));
      check({tag, " err"}, 128'(err_mismatch), 128'(exp_err));
      check({tag, " busy"}, 128'(bus.in_ready), 128'(0));
      if (bus.out_ready) begin
         @(negedge clk);
         check({tag, " vld drop"}, 128'(bus.out_valid), 128'(0));
         check({tag, " rdy back"}, 128'(bus.in_ready), 128'(1));
      end
   endtask

   initial begin
      logic [LN*AW-1:0] exp_lanes;
      logic [SW-1:0]    held;

      rst_n         = 1'b0;
      force_en      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #12;
      check("rst out_valid", 128'(bus.out_valid), 128'(0));
      check("rst out_sum", 128'(bus.out_sum), 128'(0));
      check("rst err", 128'(err_mismatch), 128'(0));
      check("rst lanes", 128'(lane_data), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst in_ready", 128'(bus.in_ready), 128'(1));

      // Basic batch.
      send4(21'd1, 21'd2, 21'd3, 21'd4);
      exp_lanes = {21'd4, 21'd3, 21'd2, 21'd1};
      check("b1 lanes", 128'(lane_data), 128'(exp_lanes));
      get_result("b1", 22'd10, 1'b0);

      // Full-scale operands wrap to 22 bits without error.
      send4(21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF);
      get_result("wrap", 22'h3FFFFC, 1'b0);

      // Back-pressure on the result.
      bus.out_ready = 1'b0;
      send4(21'd7, 21'd8, 21'd9, 21'd10);
      get_result("bp", 22'd34, 1'b0);
      held = bus.out_sum;
      bus.in_valid = 1'b1;
      bus.in_data  = 21'd99;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp hold sum", 128'(bus.out_sum), 128'(held));
         check("bp hold vld", 128'(bus.out_valid), 128'(1));
         check("bp no ready", 128'(bus.in_ready), 128'(0));
      end
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp release vld", 128'(bus.out_valid), 128'(0));
      check("bp release rdy", 128'(bus.in_ready), 128'(1));

      // Gapped input: 5,_,6,_,7,_,8.
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = AW'(5 + i);
         @(negedge clk);
         if (i < 3) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 21'd77;
            @(negedge clk);
            check("gap ready", 128'(bus.in_ready), 128'(1));
         end
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      get_result("gap", 22'd26, 1'b0);

      // Faulty tree result, then sticky flag through a good batch.
      force_en = 1'b1;
      send4(21'd1, 21'd2, 21'd3, 21'd4);
      get_result("bad", 22'd11, 1'b1);
      force_en = 1'b0;
      send4(21'd2, 21'd2, 21'd2, 21'd2);
      get_result("sticky", 22'd8, 1'b1);

      // Reset in the middle of a batch.
      bus.in_valid = 1'b1;
      bus.in_data  = 21'd9;
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      rst_n = 1'b0;
      #1;
      check("mid rst lanes", 128'(lane_data), 128'(0));
      check("mid rst sum", 128'(bus.out_sum), 128'(0));
      check("mid rst vld", 128'(bus.out_valid), 128'(0));
      check("mid rst err", 128'(err_mismatch), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send4(21'd5, 21'd5, 21'd5, 21'd5);
      get_result("post rst", 22'd20, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
